// File: rtl/mult4_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// mult4_sequencer_pkg: shared states, widths and partial-product placement.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mult4_sequencer_pkg;

  localparam int OP_W   = 4;
  localparam int RES_W  = 8;
  localparam int STEP_W = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Step {i,j} weights the 2x2 product by 4^(i+j).
  function automatic logic [RES_W-1:0] place_pp(input logic [3:0] w,
                                                input logic [STEP_W-1:0] step);
    logic [RES_W-1:0] ext;
    ext = {4'b0000, w};
    case (step)
      2'd0:    place_pp = ext;
      2'd1,
      2'd2:    place_pp = ext << 2;
      default: place_pp = ext << 4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult4_sequencer_cell.sv
// ----------------------------------------------------------------------------
// TwoBitMultiplier: combinational 2x2 unsigned multiplier cell.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module TwoBitMultiplier (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic [3:0] w
);

  assign w = {2'b00, A} * {2'b00, B};

endmodule

`default_nettype wire

// File: rtl/mult4_sequencer.sv
// ----------------------------------------------------------------------------
// mult4_sequencer: two-requester 4x4 multiplier sharing one 2x2 cell.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mult4_sequencer
  import mult4_sequencer_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [OP_W-1:0]  a0,
  input  logic [OP_W-1:0]  b0,
  input  logic             req1,
  input  logic [OP_W-1:0]  a1,
  input  logic [OP_W-1:0]  b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [RES_W-1:0] p
);

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic              id_q, id_d;
  logic              last_q, last_d;
  logic              done_id_q, done_id_d;
  logic [RES_W-1:0]  acc_q, acc_d, p_q, p_d;
  logic [RES_W-1:0]  acc_sum;
  logic              win1;
  logic [1:0]        cell_a, cell_b;
  logic [3:0]        cell_w;

  // Requester 1 wins alone, or on conflict when round-robin says 0 went last.
  assign win1 = req1 & (~req0 | (~FIXED_PRIO & ~last_q));
  assign gnt0 = (state_q == IDLE) & req0 & ~win1;
  assign gnt1 = (state_q == IDLE) & win1;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = done_id_q;
  assign p       = p_q;

  always_comb begin
    cell_a = 2'b00;
    cell_b = 2'b00;
    if (state_q == MUL) begin
      cell_a = step_q[1] ? a_q[3:2] : a_q[1:0];
      cell_b = step_q[0] ? b_q[3:2] : b_q[1:0];
    end
  end

  TwoBitMultiplier u_cell (
    .A (cell_a),
    .B (cell_b),
    .w (cell_w)
  );

  assign acc_sum = acc_q + place_pp(cell_w, step_q);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    last_d    = last_q;
    acc_d     = acc_q;
    p_d       = p_q;
    done_id_d = done_id_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          a_d     = win1 ? a1 : a0;
          b_d     = win1 ? b1 : b0;
          id_d    = win1;
          last_d  = win1;
          acc_d   = '0;
          step_d  = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d   = DONE;
          p_d       = acc_sum;
          done_id_d = id_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      acc_q     <= '0;
      p_q       <= '0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      done_id_q <= done_id_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult4_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mult4_sequencer: directed and random stimulus against a behavioural model.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mult4_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, done, done_id;
  logic [7:0] p;

  logic       fgnt0, fgnt1, fbusy, fdone, fdone_id;
  logic [7:0] fp;
  logic       freq = 1'b1;
  logic [3:0] fa0 = 4'd3, fb0 = 4'd5, fa1 = 4'd7, fb1 = 4'd2;

  always #5 clk = ~clk;

  mult4_sequencer #(.FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .p(p)
  );

  mult4_sequencer #(.FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .rst(rst),
    .req0(freq), .a0(fa0), .b0(fb0),
    .req1(freq), .a1(fa1), .b1(fb1),
    .gnt0(fgnt0), .gnt1(fgnt1), .busy(fbusy), .done(fdone),
    .done_id(fdone_id), .p(fp)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int gcyc  = 0;
  int nfix  = 0;

  // Model: phase 0 = idle, 1..4 = multiplying, 5 = result cycle.
  int         m_phase = 0;
  bit         m_last  = 1'b1;
  bit         m_id, m_did;
  logic [7:0] m_prod, m_p;
  bit         e_g0, e_g1, win;
  bit         last_g0, last_g1;
  bit         hold0, hold1;

  typedef struct {
    logic [7:0] p;
    logic       id;
    int         cyc;
  } done_t;
  done_t dlog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_last  = 1'b1;
      m_p     = 8'h00;
      m_did   = 1'b0;
    end
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (m_phase == 0 && (req0 || req1)) begin
      win  = (req0 && req1) ? !m_last : req1;
      e_g0 = !win;
      e_g1 = win;
    end
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("busy", busy, m_phase != 0);
    chk("done", done, m_phase == 5);
    chk("done_id", done_id, m_did);
    chk("p", p, m_p);
    if (gnt0 || gnt1) gcyc = cyc;
    if (done) dlog.push_back('{p, done_id, cyc});
    last_g0 = e_g0;
    last_g1 = e_g1;
    if (!rst) begin
      case (m_phase)
        0: if (e_g0 || e_g1) begin
             m_phase = 1;
             m_id    = e_g1;
             m_last  = e_g1;
             m_prod  = e_g1 ? 8'(a1) * 8'(b1) : 8'(a0) * 8'(b0);
           end
        1, 2, 3: m_phase = m_phase + 1;
        4: begin
             m_phase = 5;
             m_p     = m_prod;
             m_did   = m_id;
           end
        default: m_phase = 0;
      endcase
    end
    chk("fix_gnt1", fgnt1, 1'b0);
    if (fdone) begin
      nfix++;
      chk("fix_p", fp, 8'd15);
      chk("fix_id", fdone_id, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (last_g0 && !hold0) req0 = 1'b0;
    if (last_g1 && !hold1) req1 = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (dlog.size() < n && k < 60) begin
      tick();
      k++;
    end
    if (dlog.size() < n) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d results expected %0d", dlog.size(), n);
    end
  endtask

  task automatic wait_grant0();
    int k = 0;
    do begin
      tick();
      k++;
    end while (!last_g0 && k < 20);
    if (!last_g0) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: got no grant expected gnt0");
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    hold0 = 1'b0; hold1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    n = dlog.size();
    req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
    wait_done(n + 1);
    if (dlog.size() > n) begin
      chk("t1_p", dlog[n].p, 8'hE1);
      chk("t1_id", dlog[n].id, 1'b0);
      chk("t1_latency", dlog[n].cyc - gcyc, 5);
    end

    n = dlog.size();
    req1 = 1'b1; a1 = 4'd9; b1 = 4'd6;
    wait_done(n + 1);
    if (dlog.size() > n) begin
      chk("t2_p", dlog[n].p, 8'h36);
      chk("t2_id", dlog[n].id, 1'b1);
    end

    n = dlog.size();
    req0 = 1'b1; a0 = 4'd0; b0 = 4'($urandom_range(1, 15));
    wait_done(n + 1);
    if (dlog.size() > n) begin
      chk("t3_zero_p", dlog[n].p, 8'h00);
      chk("t3_latency", dlog[n].cyc - gcyc, 5);
    end

    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
    req1 = 1'b1; a1 = 4'd7; b1 = 4'd2;
    hold0 = 1'b1; hold1 = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = dlog.size();
    wait_done(n + 3);
    req0 = 1'b0; req1 = 1'b0;
    hold0 = 1'b0; hold1 = 1'b0;
    if (dlog.size() >= n + 3) begin
      chk("rr_id0", dlog[n].id, 1'b0);
      chk("rr_p0", dlog[n].p, 8'd15);
      chk("rr_id1", dlog[n+1].id, 1'b1);
      chk("rr_p1", dlog[n+1].p, 8'd14);
      chk("rr_id2", dlog[n+2].id, 1'b0);
      chk("rr_gap1", dlog[n+1].cyc - dlog[n].cyc, 6);
      chk("rr_gap2", dlog[n+2].cyc - dlog[n+1].cyc, 6);
    end
    tick();

    req0 = 1'b1; a0 = 4'd5; b0 = 4'd7;
    wait_grant0();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_p", p, 8'h00);
    tick();
    rst = 1'b0;
    n = dlog.size();
    repeat (8) tick();
    chk("rst_no_done", dlog.size(), n);
    req0 = 1'b1; a0 = 4'd4; b0 = 4'd4;
    wait_done(n + 1);
    if (dlog.size() > n) chk("rst_after_p", dlog[n].p, 8'h10);

    for (int k = 0; k < 400; k++) begin
      tick();
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom);
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom);
      end
    end
    for (int k = 0; k < 40 && (req0 || req1); k++) tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) tick();

    n = dlog.size();
    hold0 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a0 = 4'(i % 16);
      b0 = 4'(i / 16);
      req0 = 1'b1;
      wait_grant0();
    end
    req0 = 1'b0;
    hold0 = 1'b0;
    wait_done(n + 256);
    if (dlog.size() >= n + 256) begin
      for (int i = 0; i < 256; i++) begin
        chk("sweep_p", dlog[n+i].p, 32'((i % 16) * (i / 16)));
        if (i > 0) chk("sweep_gap", dlog[n+i].cyc - dlog[n+i-1].cyc, 6);
      end
    end

    chk("fix_progress", nfix > 10, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
